// File: rtl/mmr_trigger_regs.sv
// mmr_trigger_regs
//
// Register-side end of the MMR trigger channel. Software arms trigger bits
// in the TSR registers over a simple word-wide register bus. The hardware
// consumer retires armed bits by returning single-cycle clear pulses. Every
// retired bit is recorded in a sticky DONE register. DONE, masked by IRQ_EN,
// drives a registered level interrupt.
//
// Word address map:
//   0    .. N-1   TSR[i]     write-1-to-set, read returns tsr[i]
//   N    .. 2N-1  DONE[i]    write-1-to-clear, read returns done[i]
//   2N   .. 3N-1  IRQ_EN[i]  plain read/write
//   3N   and up   writes ignored, reads return 0 (rd_valid still pulses)
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-high reset
//   wr_en          write strobe, one word per cycle
//   wr_addr        write word address
//   wr_data        write data
//   rd_en          read strobe
//   rd_addr        read word address
//   rd_data        registered read data, held while rd_valid is low
//   rd_valid       one-cycle pulse qualifying rd_data
//   tsr            current trigger status, to the consumer
//   tsr_invpulses  per-bit single-cycle clear pulses from the consumer
//   irq            registered level interrupt
module mmr_trigger_regs #(
   parameter int N          = 4,
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = $clog2(3*N)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid,
   output logic [WIDTH-1:0]      tsr [N],
   input  logic [WIDTH-1:0]      tsr_invpulses [N],
   output logic                  irq
);

   logic [WIDTH-1:0] tsr_q   [N];
   logic [WIDTH-1:0] tsr_d   [N];
   logic [WIDTH-1:0] done_q  [N];
   logic [WIDTH-1:0] done_d  [N];
   logic [WIDTH-1:0] irqEn_q [N];
   logic [WIDTH-1:0] irqEn_d [N];

   logic [WIDTH-1:0] rdData_q;
   logic [WIDTH-1:0] rdData_d;
   logic             rdValid_q;
   logic             irq_q;
   logic             irq_d;
   logic [WIDTH-1:0] rdMux;

   // Per-register next state. The set mask is OR-ed in after the hardware
   // clear so a software arm racing a consumer pulse is never lost. The
   // retire term is taken from the pre-update tsr and OR-ed in after the
   // W1C mask, so a retire racing a software clear is always recorded.
   // A pulse on a bit that is not armed retires nothing.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         logic [WIDTH-1:0] setMask;
         logic [WIDTH-1:0] clrMask;
         setMask = '0;
         clrMask = '0;
         irqEn_d[i] = irqEn_q[i];
         if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
            setMask = wr_data;
         end
         if (wr_en && (wr_addr == ADDR_WIDTH'(N + i))) begin
            clrMask = wr_data;
         end
         if (wr_en && (wr_addr == ADDR_WIDTH'(2*N + i))) begin
            irqEn_d[i] = wr_data;
         end
         tsr_d[i]  = (tsr_q[i] & ~tsr_invpulses[i]) | setMask;
         done_d[i] = (done_q[i] & ~clrMask) | (tsr_invpulses[i] & tsr_q[i]);
      end
   end

   // Read mux works from the current registered state, so a read that
   // collides with a write to the same word returns the old contents.
   // Unmapped addresses fall through to zero.
   always_comb begin
      rdMux = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_addr == ADDR_WIDTH'(i)) begin
            rdMux = tsr_q[i];
         end
         if (rd_addr == ADDR_WIDTH'(N + i)) begin
            rdMux = done_q[i];
         end
         if (rd_addr == ADDR_WIDTH'(2*N + i)) begin
            rdMux = irqEn_q[i];
         end
      end
      rdData_d = rd_en ? rdMux : rdData_q;
   end

   // Interrupt request is the OR of every enabled DONE bit; it is registered,
   // so it trails done/irq_en by one cycle.
   always_comb begin
      irq_d = 1'b0;
      for (int i = 0; i < N; i++) begin
         irq_d = irq_d | (|(done_q[i] & irqEn_q[i]));
      end
   end

   // State registers. Reset clears everything, including a read whose strobe
   // was already sampled, so no rd_valid follows a reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            tsr_q[i]   <= '0;
            done_q[i]  <= '0;
            irqEn_q[i] <= '0;
         end
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            tsr_q[i]   <= tsr_d[i];
            done_q[i]  <= done_d[i];
            irqEn_q[i] <= irqEn_d[i];
         end
         rdData_q  <= rdData_d;
         rdValid_q <= rd_en;
         irq_q     <= irq_d;
      end
   end

   assign tsr      = tsr_q;
   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_mmr_trigger_regs.sv
// tb_mmr_trigger_regs
//
// Directed bench for mmr_trigger_regs (N=4, WIDTH=32, ADDR_WIDTH=4).
// Word map at these parameters: TSR 0..3, DONE 4..7, IRQ_EN 8..11, 12+ unmapped.
// Read results are predicted when the read is issued and queued; they are
// popped and compared when the DUT presents rd_valid. Expected register
// values are hand-derived constants.
module tb_mmr_trigger_regs;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int AW = 4;

   logic          clock;
   logic          reset;
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [W-1:0]  wrData;
   logic          rdEn;
   logic [AW-1:0] rdAddr;
   logic [W-1:0]  rdData;
   logic          rdValid;
   logic [W-1:0]  tsr [N];
   logic [W-1:0]  tsrInvpulses [N];
   logic          irq;

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0] expQ [$];
   logic         rdIssued = 1'b0;

   mmr_trigger_regs #(
      .N          (N),
      .WIDTH      (W),
      .ADDR_WIDTH (AW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .wr_en         (wrEn),
      .wr_addr       (wrAddr),
      .wr_data       (wrData),
      .rd_en         (rdEn),
      .rd_addr       (rdAddr),
      .rd_data       (rdData),
      .rd_valid      (rdValid),
      .tsr           (tsr),
      .tsr_invpulses (tsrInvpulses),
      .irq           (irq)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: count it, and on a miss count and report it.
   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Return all inputs to idle.
   task automatic idleInputs();
      wrEn   = 1'b0;
      wrAddr = '0;
      wrData = '0;
      rdEn   = 1'b0;
      rdAddr = '0;
      for (int i = 0; i < N; i++) tsrInvpulses[i] = '0;
   endtask

   // Drive one cycle worth of bus activity. A read pushes its predicted data.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                input logic re, input logic [AW-1:0] ra, input logic [W-1:0] rexp);
      wrEn   = we;
      wrAddr = wa;
      wrData = wd;
      rdEn   = re;
      rdAddr = ra;
      if (re) begin
         expQ.push_back(rexp);
         rdIssued = 1'b1;
      end
   endtask

   // Advance through one rising edge, sample 1 time unit later, check the
   // read handshake against the scoreboard, then idle the inputs.
   task automatic tick();
      logic [W-1:0] exp;
      @(posedge clock);
      #1;
      checkOutput("rd_valid", {31'b0, rdValid}, {31'b0, rdIssued});
      if (rdIssued) begin
         if (expQ.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            exp = expQ.pop_front();
            checkOutput("rd_data", rdData, exp);
         end
      end
      rdIssued = 1'b0;
      idleInputs();
   endtask

   initial begin
      idleInputs();
      reset = 1'b1;
      #12;
      // Reset state
      checkOutput("reset_tsr0", tsr[0], 32'h0);
      checkOutput("reset_tsr3", tsr[3], 32'h0);
      checkOutput("reset_irq", {31'b0, irq}, 32'h0);
      checkOutput("reset_rd_valid", {31'b0, rdValid}, 32'h0);
      reset = 1'b0;

      // Arm TSR[0]=0xFF, retire bit 0 so done[0] is non-zero before reset
      applyStimulus(1'b1, 4'd0, 32'hFF, 1'b0, '0, '0);
      tick();
      checkOutput("arm_tsr0", tsr[0], 32'hFF);
      tsrInvpulses[0] = 32'h1;
      tick();
      checkOutput("retire_tsr0", tsr[0], 32'hFE);

      // Mid-cycle reset with a read strobe pending
      rdEn   = 1'b1;
      rdAddr = 4'd0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_tsr0", tsr[0], 32'h0);
      checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
      checkOutput("midreset_rd_valid", {31'b0, rdValid}, 32'h0);
      @(posedge clock);
      #1;
      rdEn = 1'b0;
      #2;
      reset = 1'b0;
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd4, 32'h0);
      tick();

      // Arm/retire on register 1 with its interrupt enabled
      applyStimulus(1'b1, 4'd9, 32'h1, 1'b0, '0, '0);
      tick();
      applyStimulus(1'b1, 4'd1, 32'h5, 1'b0, '0, '0);
      tick();
      checkOutput("arm_tsr1", tsr[1], 32'h5);
      tsrInvpulses[1] = 32'h1;
      tick();
      checkOutput("retire_tsr1", tsr[1], 32'h4);
      checkOutput("irq_lag", {31'b0, irq}, 32'h0);
      tick();
      checkOutput("irq_set", {31'b0, irq}, 32'h1);
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 32'h1);
      tick();

      // Set wins over a same-cycle hardware clear
      applyStimulus(1'b1, 4'd2, 32'h1, 1'b0, '0, '0);
      tick();
      checkOutput("arm_tsr2", tsr[2], 32'h1);
      applyStimulus(1'b1, 4'd2, 32'h1, 1'b0, '0, '0);
      tsrInvpulses[2] = 32'h1;
      tick();
      checkOutput("setwins_tsr2", tsr[2], 32'h1);
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd6, 32'h1);
      tick();

      // Clear done[1] so irq drops, then build done[0]=0x2 with IRQ_EN[0]=0x2
      applyStimulus(1'b1, 4'd5, 32'h1, 1'b0, '0, '0);
      tick();
      tick();
      checkOutput("w1c_irq_clear", {31'b0, irq}, 32'h0);
      applyStimulus(1'b1, 4'd0, 32'h2, 1'b0, '0, '0);
      tick();
      tsrInvpulses[0] = 32'h2;
      tick();
      applyStimulus(1'b1, 4'd8, 32'h2, 1'b0, '0, '0);
      tick();
      tick();
      checkOutput("irq_done0", {31'b0, irq}, 32'h1);

      // Retire wins over a same-cycle W1C
      applyStimulus(1'b1, 4'd0, 32'h2, 1'b0, '0, '0);
      tick();
      checkOutput("rearm_tsr0", tsr[0], 32'h2);
      applyStimulus(1'b1, 4'd4, 32'h2, 1'b0, '0, '0);
      tsrInvpulses[0] = 32'h2;
      tick();
      checkOutput("retirewins_tsr0", tsr[0], 32'h0);
      tick();
      checkOutput("retirewins_irq", {31'b0, irq}, 32'h1);
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd4, 32'h2);
      tick();

      // Spurious pulse on an unarmed register
      tsrInvpulses[3] = 32'h8;
      tick();
      checkOutput("spurious_tsr3", tsr[3], 32'h0);
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd7, 32'h0);
      tick();
      checkOutput("spurious_irq", {31'b0, irq}, 32'h1);

      // Back-to-back reads across every region, ending unmapped
      applyStimulus(1'b1, 4'd0, 32'hA5A5_0000, 1'b0, '0, '0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd0, 32'hA5A5_0000);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd4, 32'h2);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd8, 32'h2);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd12, 32'h0);
      tick();

      // Read/write collisions return the old value
      applyStimulus(1'b1, 4'd1, 32'h10, 1'b1, 4'd1, 32'h4);
      tick();
      checkOutput("collide_tsr1", tsr[1], 32'h14);
      applyStimulus(1'b1, 4'd10, 32'h1234, 1'b1, 4'd10, 32'h0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 4'd10, 32'h1234);
      tick();
      tick();
      checkOutput("rd_data_hold", rdData, 32'h1234);
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mmr_trigger_regs.md
Name: mmr_trigger_regs

Overview:
- Register-side (slave) end of the MMR trigger channel: owns the trigger status registers (tsr) that software arms through a simple register bus, and retires bits when the hardware consumer returns tsr_invpulses.
- Each retired bit is recorded in a sticky DONE register. DONE drives a maskable, registered interrupt.
- Sits between the PS-facing register decoder and the trigger consumers in the processing pipeline.

Parameters:
- N, 4, number of trigger registers.
- WIDTH, 32, bits per trigger register; also the register-bus data width.
- ADDR_WIDTH, $clog2(3*N), word address width; must be ≥ $clog2(3*N).

Ports:
- clock  input  1  sole clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  register write strobe, one word per cycle.
- wr_addr  input  ADDR_WIDTH  word address of the write.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  register read strobe.
- rd_addr  input  ADDR_WIDTH  word address of the read.
- rd_data  output  WIDTH  read data, registered.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- tsr  output  N x WIDTH (unpacked [N])  current trigger status, to the consumer.
- tsr_invpulses  input  N x WIDTH (unpacked [N])  per-bit single-cycle clear pulses from the consumer.
- irq  output  1  level interrupt, registered.

Behaviour:
- Register map (word addresses):
  - 0..N-1: TSR[i]. Write-1-to-set; read returns tsr[i].
  - N..2N-1: DONE[i]. Write-1-to-clear; read returns done[i].
  - 2N..3N-1: IRQ_EN[i]. Plain read/write.
  - Addresses ≥3N: writes ignored, reads return 0 with rd_valid still pulsed.
- Reset (asynchronous, immediate): tsr, done, irq_en, rd_data, rd_valid and irq all 0. A read in flight when reset asserts is dropped; no rd_valid follows.
- TSR update per bit, each cycle: tsr_next = (tsr & ~tsr_invpulses) | set_mask.
  - set_mask = wr_data when writing TSR[i], else 0.
  - Simultaneous software set and hardware clear on the same bit: set wins, so a new trigger is never lost.
- DONE update per bit: done_next = (done & ~clr_mask) | retire.
  - retire = tsr_invpulses & tsr, using the pre-update tsr.
  - clr_mask = wr_data when writing DONE[i], else 0.
  - Simultaneous retire and W1C on the same bit: retire wins.
  - Invpulse on a bit where tsr is 0: no effect on tsr or done.
- Latency:
  - Register write is visible on tsr/done/irq_en one cycle after wr_en.
  - Invpulse clears the tsr bit and sets the done bit one cycle later.
  - irq = OR over all i of |(done[i] & irq_en[i]), registered, so it follows done/irq_en by one further cycle.
- Read handshake:
  - rd_en sampled at edge t; rd_data and rd_valid=1 at t+1.
  - rd_valid returns to 0 the following cycle unless rd_en is asserted again.
  - Back-to-back reads each cycle are supported (throughput 1 per cycle).
  - rd_data holds its last value when rd_valid=0.
- Read data source: rd_data reflects register state before any same-cycle write, i.e. the old value for a read/write collision at edge t.
- Concurrency: wr_en and rd_en may be asserted in the same cycle on any addresses.
- Multiple bits and multiple registers may retire in the same cycle; all are recorded.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset mid-cycle with tsr[0]=0xFF and rd_en pending -> tsr, done, irq, rd_valid all 0 immediately; no rd_valid after release.
- Arm/retire: write TSR[1]=0x0000_0005, then pulse tsr_invpulses[1]=0x1 -> tsr[1]=0x5, then 0x4; DONE[1] reads 0x1; IRQ_EN[1]=0x1 gives irq=1 two cycles after the pulse.
- Collision set-wins: tsr[2]=0x1; same cycle write TSR[2]=0x1 and pulse invpulses[2]=0x1 -> tsr[2] stays 0x1; done[2] bit0 becomes 1.
- Collision retire-wins: done[0]=0x2; same cycle W1C DONE[0]=0x2 and retire bit1 -> done[0] stays 0x2; irq stays asserted if enabled.
- Spurious pulse: invpulses[3]=0x8 while tsr[3]=0 -> tsr[3]=0, done[3]=0, irq unchanged.
- Read pipeline: rd_en on addresses 0,N,2N,3N in consecutive cycles -> four rd_valid pulses with the correct values, the last being 0; a same-cycle write to the read address returns the old value.
